// File: rtl/alu_wb_unit.sv
// ALU-to-writeback consumer: buffers ALU results in a small FIFO and retires them in order,
// driving the arbitrated register-file write port, PC redirects and retire notifications.
module alu_wb_unit #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     alu_valid,
   input  logic [DATA_W-1:0]        alu_dst,
   input  logic                     alu_wb_wr,
   input  logic [REG_W-1:0]         alu_reg_dst,
   input  logic                     alu_pc_branch,
   output logic                     alu_ready,
   input  logic                     flush,
   input  logic                     rf_wr_gnt,
   output logic                     rf_wr_req,
   output logic                     rf_wr_en,
   output logic [REG_W-1:0]         rf_wr_addr,
   output logic [DATA_W-1:0]        rf_wr_data,
   output logic                     pc_redirect_valid,
   output logic [DATA_W-1:0]        pc_redirect_target,
   output logic                     retire_valid,
   output logic [REG_W-1:0]         retire_reg,
   output logic [$clog2(DEPTH):0]   occupancy
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   // Entry storage carries no reset; validity is defined solely by r_count.
   logic [DATA_W-1:0] r_dst_mem [DEPTH];
   logic [REG_W-1:0]  r_reg_mem [DEPTH];
   logic [DEPTH-1:0]  r_wbwr_mem;
   logic [DEPTH-1:0]  r_br_mem;

   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [CNT_W-1:0]  r_count;

   logic              w_hv;
   logic              w_need_wr;
   logic              w_enq;
   logic              w_deq;
   logic [DATA_W-1:0] w_head_dst;
   logic [REG_W-1:0]  w_head_reg;
   logic              w_head_wbwr;
   logic              w_head_br;

   assign w_head_dst  = r_dst_mem[r_rd_ptr];
   assign w_head_reg  = r_reg_mem[r_rd_ptr];
   assign w_head_wbwr = r_wbwr_mem[r_rd_ptr];
   assign w_head_br   = r_br_mem[r_rd_ptr];

   assign alu_ready = (r_count != FULL_CNT);
   assign w_hv      = (r_count != '0);
   // Register 0 is hardwired, so such entries never compete for the write port.
   assign w_need_wr = w_head_wbwr && (w_head_reg != '0);
   assign rf_wr_req = w_hv && w_need_wr;
   assign w_enq     = alu_valid && alu_ready && !flush && rst_n;
   assign w_deq     = w_hv && (!w_need_wr || rf_wr_gnt) && !flush && rst_n;

   assign rf_wr_en   = w_deq && w_need_wr;
   assign rf_wr_addr = w_head_reg;
   assign rf_wr_data = w_head_dst;
   assign occupancy  = r_count;

   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_dst_mem[r_wr_ptr]  <= alu_dst;
         r_reg_mem[r_wr_ptr]  <= alu_reg_dst;
         r_wbwr_mem[r_wr_ptr] <= alu_wb_wr;
         r_br_mem[r_wr_ptr]   <= alu_pc_branch;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Flush blocks w_deq, which already silences the pulses in the following cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         retire_valid       <= 1'b0;
         retire_reg         <= '0;
         pc_redirect_valid  <= 1'b0;
         pc_redirect_target <= '0;
      end else begin
         retire_valid      <= w_deq && w_head_wbwr;
         pc_redirect_valid <= w_deq && w_head_br;
         if (w_deq && w_head_wbwr) retire_reg <= w_head_reg;
         if (w_deq && w_head_br) pc_redirect_target <= w_head_dst;
      end
   end
endmodule

// File: tb/tb_alu_wb_unit.sv
// Scoreboard bench for alu_wb_unit: stimulus queues expected write/retire/redirect events,
// a negedge monitor pops and compares them whenever the DUT emits one.
module tb_alu_wb_unit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        alu_valid;
   logic [31:0] alu_dst;
   logic        alu_wb_wr;
   logic [4:0]  alu_reg_dst;
   logic        alu_pc_branch;
   logic        alu_ready;
   logic        flush;
   logic        rf_wr_gnt;
   logic        rf_wr_req;
   logic        rf_wr_en;
   logic [4:0]  rf_wr_addr;
   logic [31:0] rf_wr_data;
   logic        pc_redirect_valid;
   logic [31:0] pc_redirect_target;
   logic        retire_valid;
   logic [4:0]  retire_reg;
   logic [2:0]  occupancy;

   int n_vec = 0;
   int n_bad = 0;

   logic [36:0] wr_q [$];
   logic [4:0]  ret_q [$];
   logic [31:0] redir_q [$];

   always #5 clk = ~clk;

   alu_wb_unit #(.DATA_W(32), .REG_W(5), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_dst(alu_dst), .alu_wb_wr(alu_wb_wr),
      .alu_reg_dst(alu_reg_dst), .alu_pc_branch(alu_pc_branch), .alu_ready(alu_ready),
      .flush(flush), .rf_wr_gnt(rf_wr_gnt), .rf_wr_req(rf_wr_req), .rf_wr_en(rf_wr_en),
      .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
      .pc_redirect_valid(pc_redirect_valid), .pc_redirect_target(pc_redirect_target),
      .retire_valid(retire_valid), .retire_reg(retire_reg), .occupancy(occupancy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [31:0] d, input logic wb, input logic [4:0] r, input logic br);
      alu_valid     = 1'b1;
      alu_dst       = d;
      alu_wb_wr     = wb;
      alu_reg_dst   = r;
      alu_pc_branch = br;
   endtask

   // Expected events of an accepted entry, derived from its own fields.
   task automatic expect_entry(input logic [31:0] d, input logic wb, input logic [4:0] r, input logic br);
      if (wb && r != 5'd0) wr_q.push_back({r, d});
      if (wb) ret_q.push_back(r);
      if (br) redir_q.push_back(d);
   endtask

   always @(negedge clk) begin
      if (rf_wr_en) begin
         n_vec++;
         if (wr_q.size() == 0) begin
            n_bad++;
            $display("FAIL rf_write: unexpected write addr=%0d data=%h, none expected", rf_wr_addr, rf_wr_data);
         end else begin
            logic [36:0] e;
            e = wr_q.pop_front();
            if ({rf_wr_addr, rf_wr_data} !== e) begin
               n_bad++;
               $display("FAIL rf_write: got addr=%0d data=%h, expected addr=%0d data=%h", rf_wr_addr, rf_wr_data, e[36:32], e[31:0]);
            end else $display("ok   rf_write: addr=%0d data=%h", rf_wr_addr, rf_wr_data);
         end
      end
      if (retire_valid) begin
         n_vec++;
         if (ret_q.size() == 0) begin
            n_bad++;
            $display("FAIL retire: unexpected retire reg=%0d, none expected", retire_reg);
         end else begin
            logic [4:0] e;
            e = ret_q.pop_front();
            if (retire_reg !== e) begin
               n_bad++;
               $display("FAIL retire: got reg=%0d, expected reg=%0d", retire_reg, e);
            end else $display("ok   retire: reg=%0d", retire_reg);
         end
      end
      if (pc_redirect_valid) begin
         n_vec++;
         if (redir_q.size() == 0) begin
            n_bad++;
            $display("FAIL redirect: unexpected target=%h, none expected", pc_redirect_target);
         end else begin
            logic [31:0] e;
            e = redir_q.pop_front();
            if (pc_redirect_target !== e) begin
               n_bad++;
               $display("FAIL redirect: got target=%h, expected target=%h", pc_redirect_target, e);
            end else $display("ok   redirect: target=%h", pc_redirect_target);
         end
      end
   end

   initial begin
      rst_n = 1'b0; alu_valid = 1'b0; alu_dst = '0; alu_wb_wr = 1'b0;
      alu_reg_dst = '0; alu_pc_branch = 1'b0; flush = 1'b0; rf_wr_gnt = 1'b0;
      step(); step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_occupancy", 32'(occupancy), 32'd0);
      chk("reset_ready", 32'(alu_ready), 32'd1);
      chk("reset_wr_req", 32'(rf_wr_req), 32'd0);
      chk("reset_retire", 32'(retire_valid), 32'd0);
      chk("reset_redirect", 32'(pc_redirect_valid), 32'd0);

      // Single write with the grant held high.
      step();
      rf_wr_gnt = 1'b1;
      offer(32'h0000_1234, 1'b1, 5'd5, 1'b0);
      @(negedge clk);
      chk("single_ready", 32'(alu_ready), 32'd1);
      if (alu_ready) expect_entry(32'h0000_1234, 1'b1, 5'd5, 1'b0);
      step();
      alu_valid = 1'b0;
      @(negedge clk);
      chk("single_wr_en", 32'(rf_wr_en), 32'd1);
      chk("single_occ1", 32'(occupancy), 32'd1);
      step();
      @(negedge clk);
      chk("single_retire", 32'(retire_valid), 32'd1);
      chk("single_occ0", 32'(occupancy), 32'd0);

      // Grant stall fills the FIFO; the fifth request waits on backpressure.
      step();
      rf_wr_gnt = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         offer(32'h100 + 32'(i), 1'b1, 5'(i), 1'b0);
         @(negedge clk);
         chk($sformatf("bp_ready_%0d", i), 32'(alu_ready), (i < 5) ? 32'd1 : 32'd0);
         if (alu_ready) expect_entry(32'h100 + 32'(i), 1'b1, 5'(i), 1'b0);
         step();
      end
      rf_wr_gnt = 1'b1;
      @(negedge clk);
      chk("full_occ", 32'(occupancy), 32'd4);
      chk("full_ready_with_deq", 32'(alu_ready), 32'd0);
      chk("full_wr_en", 32'(rf_wr_en), 32'd1);
      step();
      @(negedge clk);
      chk("after_full_occ", 32'(occupancy), 32'd3);
      chk("after_full_ready", 32'(alu_ready), 32'd1);
      if (alu_ready) expect_entry(32'h105, 1'b1, 5'd5, 1'b0);
      step();
      alu_valid = 1'b0;
      repeat (6) step();
      @(negedge clk);
      chk("drain_occ", 32'(occupancy), 32'd0);

      // Branch to register 0: no grant needed, no register write.
      step();
      rf_wr_gnt = 1'b0;
      offer(32'h8000_0040, 1'b1, 5'd0, 1'b1);
      expect_entry(32'h8000_0040, 1'b1, 5'd0, 1'b1);
      step();
      alu_valid = 1'b0;
      @(negedge clk);
      chk("r0_wr_req", 32'(rf_wr_req), 32'd0);
      chk("r0_wr_en", 32'(rf_wr_en), 32'd0);
      chk("r0_occ", 32'(occupancy), 32'd1);
      step();
      @(negedge clk);
      chk("r0_redirect", 32'(pc_redirect_valid), 32'd1);
      chk("r0_retire", 32'(retire_valid), 32'd1);
      chk("r0_occ0", 32'(occupancy), 32'd0);

      // Flush with a concurrent request and grant.
      step();
      for (int i = 6; i <= 8; i++) begin
         offer(32'h200 + 32'(i), 1'b1, 5'(i), (i == 7));
         step();
      end
      offer(32'h0000_0999, 1'b1, 5'd9, 1'b1);
      flush = 1'b1;
      rf_wr_gnt = 1'b1;
      @(negedge clk);
      chk("flush_wr_en", 32'(rf_wr_en), 32'd0);
      chk("flush_ready_precount", 32'(alu_ready), 32'd1);
      chk("flush_occ_before", 32'(occupancy), 32'd3);
      step();
      flush = 1'b0;
      alu_valid = 1'b0;
      @(negedge clk);
      chk("flush_occ_after", 32'(occupancy), 32'd0);
      chk("flush_retire", 32'(retire_valid), 32'd0);
      chk("flush_redirect", 32'(pc_redirect_valid), 32'd0);
      repeat (3) step();

      // Reset mid-stream with a branch dequeuing and one entry behind it.
      rf_wr_gnt = 1'b0;
      offer(32'h0000_010A, 1'b1, 5'd10, 1'b0);
      step();
      offer(32'h0000_00A0, 1'b0, 5'd3, 1'b1);
      step();
      offer(32'h0000_010C, 1'b1, 5'd12, 1'b0);
      rf_wr_gnt = 1'b1;
      expect_entry(32'h0000_010A, 1'b1, 5'd10, 1'b0);
      @(negedge clk);
      chk("rst_pre_occ", 32'(occupancy), 32'd2);
      step();
      offer(32'h0000_010B, 1'b1, 5'd11, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_pre_occ2", 32'(occupancy), 32'd2);
      step();
      rst_n = 1'b1;
      alu_valid = 1'b0;
      @(negedge clk);
      chk("rst_occ", 32'(occupancy), 32'd0);
      chk("rst_ready", 32'(alu_ready), 32'd1);
      chk("rst_redirect", 32'(pc_redirect_valid), 32'd0);
      chk("rst_target", pc_redirect_target, 32'd0);
      chk("rst_retire", 32'(retire_valid), 32'd0);
      chk("rst_retire_reg", 32'(retire_reg), 32'd0);
      chk("rst_wr_req", 32'(rf_wr_req), 32'd0);
      chk("rst_wr_en", 32'(rf_wr_en), 32'd0);
      repeat (6) step();
      @(negedge clk);
      chk("end_wr_pending", 32'(wr_q.size()), 32'd0);
      chk("end_ret_pending", 32'(ret_q.size()), 32'd0);
      chk("end_redir_pending", 32'(redir_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/alu_wb_unit.md
Name: alu_wb_unit

Overview:
- Consumer end of the ALU-to-writeback interface.
- Accepts ALU results (dst value plus forwarded control: wb_wr, reg_dst, pc_branch) into a small FIFO.
- Retires them in order: writes the register file through an arbitrated write port, issues PC redirects for branch results, and pulses a retire notification for the issue scoreboard.
- Sits between the ALU output register and the register file / fetch redirect logic.

Parameters:
- DATA_W, 32, width of the result value (imm_t).
- REG_W, 5, width of a register index (reg_t).
- DEPTH, 4, FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- alu_valid  in  1  request valid; carries alu_to_wb_req_t.fur_sig.valid
- alu_dst  in  DATA_W  result value
- alu_wb_wr  in  1  result must be written to the register file
- alu_reg_dst  in  REG_W  destination register
- alu_pc_branch  in  1  result is a branch target
- alu_ready  out  1  FIFO can accept this cycle
- flush  in  1  discard all buffered entries
- rf_wr_gnt  in  1  register-file write port granted this cycle
- rf_wr_req  out  1  head entry wants the write port
- rf_wr_en  out  1  register-file write strobe
- rf_wr_addr  out  REG_W  write address
- rf_wr_data  out  DATA_W  write data
- pc_redirect_valid  out  1  one-cycle redirect pulse
- pc_redirect_target  out  DATA_W  redirect address
- retire_valid  out  1  one-cycle retire pulse
- retire_reg  out  REG_W  register released to the scoreboard
- occupancy  out  $clog2(DEPTH)+1  number of valid entries

Behaviour:
- Storage is a circular FIFO with rd/wr pointers of $clog2(DEPTH) bits plus a count register.
  - Pointers wrap DEPTH-1 to 0.
  - occupancy = count.
- alu_ready = (count != DEPTH). This is derived from registered state only, so it has no combinational path from any input.
- Enqueue happens when alu_valid && alu_ready.
  - The entry stores dst, wb_wr, reg_dst and pc_branch.
- When full, alu_ready = 0 even if a dequeue occurs in the same cycle; there is no full-pass-through.
- Minimum latency is 1 cycle: an entry enqueued in cycle N is the head at the earliest in cycle N+1. There is no bypass when empty.
- Head definitions (all combinational from registered state):
  - hv = count != 0
  - need_wr = head.wb_wr && head.reg_dst != 0
  - rf_wr_req = hv && need_wr
- Dequeue condition: deq = hv && (!need_wr || rf_wr_gnt) && !flush.
- Register-file write signals:
  - rf_wr_en = deq && need_wr (combinational, same cycle as the grant).
  - rf_wr_addr = head.reg_dst and rf_wr_data = head.dst at all times; both are don't-care when rf_wr_en = 0.
- Writes to register 0 are suppressed. Such entries dequeue without needing a grant.
- Registered pulses, asserted in cycle N+1 for a dequeue in cycle N:
  - retire_valid = 1 with retire_reg = head.reg_dst, when head.wb_wr = 1 (including reg 0).
  - pc_redirect_valid = 1 with pc_redirect_target = head.dst, when head.pc_branch = 1.
  - Both pulse in the same cycle if both bits are set.
- Simultaneous enqueue and dequeue when not full: count is unchanged and both pointers advance.
- flush (synchronous) takes priority over everything:
  - In the flush cycle: count = 0, rd_ptr = wr_ptr = 0; enqueue and dequeue are both blocked, and rf_wr_en = 0.
  - In the next cycle: pc_redirect_valid and retire_valid are forced 0.
  - alu_ready still reflects the pre-flush count during the flush cycle, but the offered request is dropped.
- Reset (rst_n = 0 at a clk edge), including mid-operation, produces the same state as flush, and additionally:
  - All registered outputs go to 0.
  - pc_redirect_target and retire_reg go to 0.
  - alu_ready = 1 from the first cycle after reset.
- Entry storage is not reset; only count and pointers are.
- rf_wr_gnt while rf_wr_req = 0 is ignored.

Test Plan:
- Single write:
  - Stimulus: enqueue dst=0x0000_1234, wb_wr=1, reg=5, pc_branch=0, with rf_wr_gnt tied 1.
  - Required: rf_wr_en=1, addr=5, data=0x1234 one cycle after the enqueue; retire_valid=1, retire_reg=5 the following cycle; occupancy returns to 0.
- Grant stall and backpressure:
  - Stimulus: rf_wr_gnt=0; enqueue 5 writes to regs 1..5 back-to-back.
  - Required:
    - alu_ready drops after the 4th; occupancy=4; the 5th is held by the sender.
    - After rf_wr_gnt=1, writes regs 1,2,3,4,5 in order, one per cycle, with no loss or duplication.
    - Pointers wrap correctly.
- Branch and register 0:
  - Stimulus: enqueue dst=0x8000_0040, pc_branch=1, wb_wr=1, reg=0, with rf_wr_gnt=0.
  - Required: the entry dequeues without a grant; rf_wr_en stays 0; next cycle pc_redirect_valid=1 with target 0x8000_0040 and retire_valid=1 with retire_reg=0.
- Flush:
  - Stimulus: fill 3 entries with gnt=0; assert flush together with a new alu_valid and gnt=1.
  - Required: no rf_wr_en, no redirect or retire pulse; occupancy=0 next cycle; the concurrent request is dropped.
- Full with simultaneous dequeue:
  - Stimulus: FIFO full, gnt=1, alu_valid=1.
  - Required: alu_ready=0 and one entry leaves; next cycle occupancy=3, alu_ready=1, and the request is accepted.
- Reset mid-stream:
  - Stimulus: rst_n=0 for 1 cycle with 2 entries buffered and a redirect pulse pending.
  - Required: all outputs 0 after the reset edge; occupancy=0; alu_ready=1; the old entries never appear.
